// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample packer: default widths, packing ratio,
// capture counter width and the capture FSM state encoding.
package adc_pkg;

  localparam int unsigned IN_DWIDTH_DEF  = 64;
  localparam int unsigned OUT_DWIDTH_DEF = 256;
  localparam int unsigned RATIO_DEF      = OUT_DWIDTH_DEF / IN_DWIDTH_DEF;
  localparam int unsigned CNT_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/adc_sample_packer_if.sv
// ADC beat stream (AXI-Stream style, no backpressure in practice).
//   tdata  : raw ADC beat
//   tvalid : beat qualifier
//   tready : sink ready (the packer ties it high)
interface adc_sample_packer_if #(
  parameter int unsigned DWIDTH = adc_pkg::IN_DWIDTH_DEF
);

  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/adc_lane_packer.sv
// Packs RATIO consecutive accepted beats into one wide word, lane 0 at the LSBs.
// Ports:
//   clk_i, reset_ni : clock, async active-low reset (control state only)
//   clear_i         : synchronous lane counter clear
//   beat_valid_i    : accept beat_data_i into the current lane
//   beat_data_i     : input beat
//   word_o          : completed word, held between valid pulses (no reset)
//   word_valid_o    : one-cycle pulse, one cycle after the beat filling the last lane
module adc_lane_packer #(
  parameter int unsigned IN_DWIDTH  = 64,
  parameter int unsigned OUT_DWIDTH = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic                  beat_valid_i,
  input  logic [IN_DWIDTH-1:0]  beat_data_i,
  output logic [OUT_DWIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int unsigned RATIO  = OUT_DWIDTH / IN_DWIDTH;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [LANE_W-1:0]     lane_cnt_q;
  logic [OUT_DWIDTH-1:0] lane_buf_q;
  logic [OUT_DWIDTH-1:0] word_c;
  logic                  last_lane_c;

  assign last_lane_c = (lane_cnt_q == LANE_W'(RATIO - 1));

  // Buffer with the incoming beat merged into its lane.
  always_comb begin
    word_c = lane_buf_q;
    word_c[int'(lane_cnt_q) * IN_DWIDTH +: IN_DWIDTH] = beat_data_i;
  end

  // Lane counter and word strobe.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lane_cnt_q   <= '0;
      word_valid_o <= 1'b0;
    end else begin
      word_valid_o <= beat_valid_i && last_lane_c;
      if (clear_i) begin
        lane_cnt_q <= '0;
      end else if (beat_valid_i) begin
        lane_cnt_q <= last_lane_c ? '0 : LANE_W'(lane_cnt_q + 1'b1);
      end
    end
  end

  // Wide data path kept reset-free; stale lanes are always overwritten before use.
  always_ff @(posedge clk_i) begin
    if (beat_valid_i) begin
      lane_buf_q <= word_c;
      if (last_lane_c) begin
        word_o <= word_c;
      end
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// ADC capture engine: arm / trigger / capture N packed words / done.
// Ports:
//   clk_i, reset_ni   : sole clock, async active-low reset
//   s_axis_adc        : ADC beat stream (slave), tready tied high
//   arm_i             : arm request, latches capture_len_i (IDLE only)
//   trigger_i         : capture start (ARMED only)
//   abort_i           : cancel capture from ARMED or CAPTURE
//   capture_len_i     : packed words minus one
//   adc_data_o        : packed word
//   adc_data_valid_o  : one-cycle qualifier per packed word
//   adc_capture_en_o  : high while the current capture is producing words
//   busy_o            : high outside IDLE
//   done_o            : one-cycle pulse after the final word
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int unsigned IN_DWIDTH  = IN_DWIDTH_DEF,
  parameter int unsigned OUT_DWIDTH = OUT_DWIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  adc_sample_packer_if.slave    s_axis_adc,
  input  logic                  arm_i,
  input  logic                  trigger_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      capture_len_i,
  output logic [OUT_DWIDTH-1:0] adc_data_o,
  output logic                  adc_data_valid_o,
  output logic                  adc_capture_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               busy_d, done_d, capture_en_d;
  logic               beat_accept_c;
  logic               lane_clear_c;

  assign s_axis_adc.tready = 1'b1;

  // Abort wins over a beat that would complete a word.
  assign beat_accept_c = (state_q == ST_CAPTURE) && s_axis_adc.tvalid && !abort_i;
  assign lane_clear_c  = (state_q != ST_CAPTURE) || abort_i;

  adc_lane_packer #(
    .IN_DWIDTH  (IN_DWIDTH),
    .OUT_DWIDTH (OUT_DWIDTH)
  ) u_lane_packer (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .clear_i      (lane_clear_c),
    .beat_valid_i (beat_accept_c),
    .beat_data_i  (s_axis_adc.tdata),
    .word_o       (adc_data_o),
    .word_valid_o (adc_data_valid_o)
  );

  // State and registered control outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q          <= ST_IDLE;
      word_cnt_q       <= '0;
      len_q            <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      adc_capture_en_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_cnt_q       <= word_cnt_d;
      len_q            <= len_d;
      busy_o           <= busy_d;
      done_o           <= done_d;
      adc_capture_en_o <= capture_en_d;
    end
  end

  // Next state; outputs follow the next state so they line up with it.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          len_d   = capture_len_i;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end else if (trigger_i) begin
          state_d    = ST_CAPTURE;
          word_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end else if (adc_data_valid_o) begin
          // Compare before incrementing so len 0xFFFFFFFF never wraps.
          if (word_cnt_q == len_q) begin
            state_d = ST_DONE;
          end else begin
            word_cnt_d = CNT_W'(word_cnt_q + 1'b1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    capture_en_d = (state_d == ST_CAPTURE);
  end

endmodule

// File: tb/tb_adc_sample_packer.sv
module tb_adc_sample_packer;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = 256;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic             arm, trig, abrt;
  logic [31:0]      len;
  logic [OUT_W-1:0] adc_data_o;
  logic             adc_data_valid_o, adc_capture_en_o, busy_o, done_o;

  adc_sample_packer_if #(.DWIDTH(IN_W)) s_axis_adc ();

  adc_sample_packer #(.IN_DWIDTH(IN_W), .OUT_DWIDTH(OUT_W)) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .s_axis_adc       (s_axis_adc),
    .arm_i            (arm),
    .trigger_i        (trig),
    .abort_i          (abrt),
    .capture_len_i    (len),
    .adc_data_o       (adc_data_o),
    .adc_data_valid_o (adc_data_valid_o),
    .adc_capture_en_o (adc_capture_en_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, done_cyc, last_valid_cyc;
  logic en_at_last_valid;
  logic [OUT_W-1:0] obs_words[$];
  logic [IN_W-1:0]  model_q[$];

  // Reference: RATIO accepted beats form one word, first beat in the LSBs.
  function automatic logic [OUT_W-1:0] model_word(input int k);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int l = 0; l < 4; l++) w[l*IN_W +: IN_W] = model_q[4*k + l];
    return w;
  endfunction

  task automatic clear_obs();
    obs_words.delete();
    model_q.delete();
    done_cnt = 0; done_cyc = -1; last_valid_cyc = -100; en_at_last_valid = 1'b0;
  endtask

  // One clock; outputs observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (adc_data_valid_o) begin
      obs_words.push_back(adc_data_o);
      last_valid_cyc   = cyc;
      en_at_last_valid = adc_capture_en_o;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    arm = 1'b0; trig = 1'b0; abrt = 1'b0;
    s_axis_adc.tvalid = 1'b0;
  endtask

  task automatic drive(input logic a, input logic t, input logic ab,
                       input logic v, input logic [IN_W-1:0] d);
    arm = a; trig = t; abrt = ab;
    s_axis_adc.tvalid = v;
    s_axis_adc.tdata  = d;
    step();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      drive(0, 0, 0, 0, '0);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL wait_done: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    arm = 0; trig = 0; abrt = 0; len = '0;
    s_axis_adc.tvalid = 1'b0; s_axis_adc.tdata = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    checks++;
    if ({busy_o, done_o, adc_capture_en_o, adc_data_valid_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy_o, done_o, adc_capture_en_o, adc_data_valid_o});
    end
    checks++;
    if (s_axis_adc.tready !== 1'b1) begin
      errors++;
      $display("FAIL tready: got %b expected 1", s_axis_adc.tready);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    len = 32'd3;
    drive(1, 0, 0, 0, '0);
    checks++;
    if (busy_o !== 1'b1 || adc_capture_en_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_armed: busy %b en %b expected 1 0", busy_o, adc_capture_en_o);
    end
    drive(0, 1, 0, 1, 64'hDEAD_BEEF);  // trigger-cycle beat is dropped
    checks++;
    if (adc_capture_en_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_en_rise: got %b expected 1", adc_capture_en_o);
    end
    for (int i = 1; i <= 16; i++) begin
      model_q.push_back(64'(i));
      drive(0, 0, 0, 1, 64'(i));
    end
    wait_done(10);
    checks++;
    if (obs_words.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 4", obs_words.size());
    end
    for (int k = 0; k < 4 && k < obs_words.size(); k++) begin
      checks++;
      if (obs_words[k] !== model_word(k)) begin
        errors++;
        $display("FAIL basic_word%0d: got %h expected %h", k, obs_words[k], model_word(k));
      end
    end
    checks++;
    if (done_cyc != last_valid_cyc + 1 || en_at_last_valid !== 1'b1 || adc_capture_en_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_timing: done@%0d lastvalid@%0d en_last %b en_now %b",
               done_cyc, last_valid_cyc, en_at_last_valid, adc_capture_en_o);
    end
    drive(0, 0, 0, 0, '0);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy %b done %b expected 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_len0_gaps();
    logic pat [7];
    logic [OUT_W-1:0] exp_w;
    int b;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    clear_obs();
    len = 32'd0;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) model_q.push_back(64'h100 + 64'(i));
      drive(0, 0, 0, pat[i], 64'h100 + 64'(i));
    end
    exp_w = model_word(0);
    drive(0, 0, 0, 1, 64'h999);
    checks++;
    if (adc_capture_en_o !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL len0_end: en %b done_cnt %0d expected 0 1", adc_capture_en_o, done_cnt);
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 64'h555);
    checks++;
    if (obs_words.size() != 1) begin
      errors++;
      $display("FAIL len0_count: got %0d expected 1", obs_words.size());
    end else begin
      checks++;
      if (obs_words[0] !== exp_w) begin
        errors++;
        $display("FAIL len0_word: got %h expected %h", obs_words[0], exp_w);
      end
    end
    b = 0;
  endtask

  task automatic test_arm_trig_same();
    clear_obs();
    len = 32'd1;
    drive(1, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 64'hBAD0 + 64'(i));
    checks++;
    if (busy_o !== 1'b1 || adc_capture_en_o !== 1'b0 || obs_words.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_arm: busy %b en %b words %0d expected 1 0 0",
               busy_o, adc_capture_en_o, obs_words.size());
    end
    drive(0, 1, 0, 0, '0);
    checks++;
    if (adc_capture_en_o !== 1'b1) begin
      errors++;
      $display("FAIL second_trigger: en %b expected 1", adc_capture_en_o);
    end
    len = 32'd0;  // re-arm attempt mid-capture with a shorter length
    for (int i = 0; i < 8; i++) begin
      model_q.push_back(64'h20 + 64'(i));
      drive(i == 2, 0, 0, 1, 64'h20 + 64'(i));
    end
    wait_done(10);
    checks++;
    if (obs_words.size() != 2) begin
      errors++;
      $display("FAIL arm_ignored_count: got %0d expected 2", obs_words.size());
    end else begin
      checks++;
      if (obs_words[1] !== model_word(1)) begin
        errors++;
        $display("FAIL arm_ignored_word: got %h expected %h", obs_words[1], model_word(1));
      end
    end
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic test_abort();
    clear_obs();
    len = 32'd7;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      model_q.push_back(64'h40 + 64'(i));
      drive(0, 0, 0, 1, 64'h40 + 64'(i));
    end
    drive(0, 0, 1, 0, '0);
    checks++;
    if (busy_o !== 1'b0 || adc_capture_en_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy %b en %b expected 0 0", busy_o, adc_capture_en_o);
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 64'h77);
    checks++;
    if (obs_words.size() != 1 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_words: words %0d done %0d expected 1 0", obs_words.size(), done_cnt);
    end else begin
      checks++;
      if (obs_words[0] !== model_word(0)) begin
        errors++;
        $display("FAIL abort_word0: got %h expected %h", obs_words[0], model_word(0));
      end
    end
    // Abort on the beat that would complete a word.
    clear_obs();
    len = 32'd3;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 64'h60 + 64'(i));
    drive(0, 0, 1, 1, 64'h63);
    drive(0, 0, 0, 0, '0);
    checks++;
    if (obs_words.size() != 0 || busy_o !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_priority: words %0d busy %b done %0d expected 0 0 0",
               obs_words.size(), busy_o, done_cnt);
    end
    // Re-arm after abort.
    clear_obs();
    len = 32'd0;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      model_q.push_back(64'h80 + 64'(i));
      drive(0, 0, 0, 1, 64'h80 + 64'(i));
    end
    wait_done(5);
    checks++;
    if (obs_words.size() != 1 || obs_words[0] !== model_word(0)) begin
      errors++;
      $display("FAIL rearm_word: words %0d first %h expected 1 %h", obs_words.size(),
               (obs_words.size() > 0) ? obs_words[0] : '0, model_word(0));
    end
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    len = 32'd1;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    drive(0, 0, 0, 1, 64'hAAAA_0001);
    drive(0, 0, 0, 1, 64'hAAAA_0002);
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, adc_capture_en_o, adc_data_valid_o} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", {busy_o, done_o, adc_capture_en_o, adc_data_valid_o});
    end
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    clear_obs();
    len = 32'd0;
    drive(1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      model_q.push_back(64'hC0 + 64'(i));
      drive(0, 0, 0, 1, 64'hC0 + 64'(i));
    end
    wait_done(5);
    checks++;
    if (obs_words.size() != 1 || obs_words[0] !== model_word(0)) begin
      errors++;
      $display("FAIL reset_no_stale: words %0d first %h expected 1 %h", obs_words.size(),
               (obs_words.size() > 0) ? obs_words[0] : '0, model_word(0));
    end
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic test_random();
    int n;
    logic v;
    logic [IN_W-1:0] d;
    for (int it = 0; it < 6; it++) begin
      clear_obs();
      len = 32'($urandom_range(0, 3));
      drive(1, 0, 0, 0, '0);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        drive(0, 0, 0, 1, {$urandom, $urandom});
      drive(0, 1, 0, 1, {$urandom, $urandom});
      n = 0;
      while (done_cnt == 0 && n < 200) begin
        v = ($urandom_range(0, 9) < 7);
        d = {$urandom, $urandom};
        if (v) model_q.push_back(d);
        drive(0, 0, 0, v, d);
        n++;
      end
      checks++;
      if (obs_words.size() != int'(len) + 1 || done_cnt != 1 || done_cyc != last_valid_cyc + 1) begin
        errors++;
        $display("FAIL rand%0d_count: words %0d done %0d dcyc %0d vcyc %0d expected %0d words",
                 it, obs_words.size(), done_cnt, done_cyc, last_valid_cyc, len + 1);
      end
      for (int k = 0; k < obs_words.size() && 4*k + 3 < model_q.size(); k++) begin
        checks++;
        if (obs_words[k] !== model_word(k)) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h expected %h", it, k, obs_words[k], model_word(k));
        end
      end
      drive(0, 0, 0, 0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0_gaps();
    test_arm_trig_same();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
- REQ-001 SHALL have parameter IN_DWIDTH, default 64, input beat width (four 16-bit ADC samples).
- REQ-002 SHALL have parameter OUT_DWIDTH, default 256, packed word width; OUT_DWIDTH SHALL be an integer multiple RATIO = OUT_DWIDTH/IN_DWIDTH >= 2.
- REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i input 1, sole clock; reset_ni input 1, asynchronous active-low reset.
- REQ-004 s_axis_adc_tdata input IN_DWIDTH: raw ADC beat from the converter.
- REQ-005 s_axis_adc_tvalid input 1: beat qualifier, no backpressure.
- REQ-006 s_axis_adc_tready output 1: constant 1.
- REQ-007 arm_i input 1: single-cycle arm request.
- REQ-008 trigger_i input 1: capture start, level or pulse.
- REQ-009 abort_i input 1: synchronous capture cancel.
- REQ-010 capture_len_i input 32: number of packed words minus 1, sampled on arm.
- REQ-011 adc_data_o output OUT_DWIDTH: packed word.
- REQ-012 adc_data_valid_o output 1: one-cycle qualifier per packed word.
- REQ-013 adc_capture_en_o output 1: high while words of the current capture are being produced.
- REQ-014 busy_o output 1: high in any state except IDLE.
- REQ-015 done_o output 1: one-cycle pulse after the last word.

Function
- REQ-016 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
- REQ-017 IDLE -> ARMED on arm_i; capture_len_i latched into len_q in the same cycle.
- REQ-018 ARMED -> CAPTURE on trigger_i; lane counter cleared. Beats arriving in the trigger cycle are not packed.
- REQ-019 In CAPTURE, each beat with s_axis_adc_tvalid=1 SHALL be written to lane lane_cnt, bits [lane_cnt*IN_DWIDTH +: IN_DWIDTH]; first beat goes to the LSBs.
- REQ-020 lane_cnt SHALL increment on each accepted beat and wrap RATIO-1 -> 0. It SHALL hold when tvalid=0, so gaps are tolerated.
- REQ-021 On the beat filling lane RATIO-1, adc_data_o SHALL present the completed word and adc_data_valid_o=1 on the next cycle (latency 1 from the last beat).
- REQ-022 adc_data_o SHALL hold its value between valid pulses; it is not cleared.
- REQ-023 word_cnt (32 bits) SHALL increment on each emitted word. When the emitted word has word_cnt == len_q, the state SHALL move to DONE.
- REQ-024 len_q = 0 SHALL produce exactly one word; len_q = 0xFFFFFFFF SHALL produce 2^32 words with no counter overflow before the compare.
- REQ-025 adc_capture_en_o SHALL be 1 from the CAPTURE entry cycle through the cycle of the final adc_data_valid_o, then 0.
- REQ-026 DONE SHALL last one cycle, assert done_o, and return to IDLE.
- REQ-027 arm_i outside IDLE SHALL be ignored; trigger_i outside ARMED SHALL be ignored.
- REQ-028 If arm_i and trigger_i are both high in IDLE, the block SHALL only arm; the trigger SHALL be required again.
- REQ-029 abort_i in ARMED or CAPTURE SHALL go to IDLE next cycle, clear lane_cnt and word_cnt, drop adc_capture_en_o, emit no partial word, and not pulse done_o.
- REQ-030 abort_i SHALL take priority over a simultaneous word completion.

Reset
- REQ-031 On reset_ni low: state = IDLE; lane_cnt, word_cnt and len_q = 0; adc_data_valid_o, adc_capture_en_o, busy_o and done_o = 0.
- REQ-032 The data path registers (lane buffer, adc_data_o) SHALL have no reset, to avoid CE/reset fan-out on wide buses.
- REQ-033 Reset asserted mid-capture SHALL discard the partial word; the block restarts in IDLE.

Structure
- REQ-034 The default widths, RATIO and the state enum SHALL live in the shared adc_pkg package.
- REQ-035 Lane packing SHALL be a sub-module adc_lane_packer: beat in, word plus word-valid out. The capture FSM stays in the top module.

Verification
- REQ-036 arm with len=3, trigger, 16 consecutive beats 0x1..0x10 -> 4 valids, first word = {0x4,0x3,0x2,0x1} (lane 0 at the LSBs), done_o 1 cycle after the 4th valid.
- REQ-037 len=0, beats with tvalid pattern 1,0,0,1,1,0,1 -> exactly one word, equal to beats 1-4, adc_capture_en_o falls after it.
- REQ-038 arm and trigger in the same cycle, then trigger 5 cycles later -> capture starts only at the second trigger; arm_i mid-capture has no effect.
- REQ-039 abort_i after 6 beats of an 8-word capture -> 1 word emitted, no done_o, busy_o=0 next cycle; a re-arm then captures correctly.
- REQ-040 reset_ni pulsed low asynchronously mid-word -> all control outputs 0 immediately; the next capture's first word contains no stale lanes.
